pc_step_ctrl: RTL and testbench

Generates the `PCincr` control that the program counter consumes. On a decoded WAIT instruction it holds `PCincr` low, stalling the PC. It then waits for a synchronised, debounced press-and-release of the board pushbutton. On release it issues exactly one `PCincr` pulse so the PC steps past the WAIT. It sits between the instruction decoder and the PC, replacing the PC-side edge detection on the raw button.

---
 rtl/picomips_pkg.sv | 19 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/pc_step_ctrl.sv | 107 ++++++++++
 tb/tb_pc_step_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/picomips_pkg.sv
// Shared types and constants for the picoMIPS PC single-step controller.
package picomips_pkg;

  typedef enum logic [2:0] {
    RUN,
    ARMED,
    PRESS,
    RELEASE,
    STEP
  } step_state_t;

  localparam int PC_STEP_DB_DEFAULT = 250000;
  localparam int PC_STEP_TMO_W      = 32;

  function automatic logic is_stalled(input step_state_t s);
    return (s == ARMED) || (s == PRESS) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton input path: 2-flop synchroniser followed by a run-length debouncer.
// db_level only flips after DB_CYCLES consecutive disagreeing synchronised samples.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic db_level
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic          db_q;
  logic [CW-1:0] run_cnt;

  // synchroniser stages, then debounce run counter on the stable sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      db_q    <= 1'b1;
      run_cnt <= '0;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
      if (sync_p1 == db_q) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(DB_CYCLES - 1)) begin
        db_q    <= sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign db_level = db_q;

endmodule

// File: rtl/pc_step_ctrl.sv
// WAIT-instruction stall controller: holds PCincr low until a debounced press/release,
// then issues one step pulse. Optional auto-step timeout under PC_STEP_TIMEOUT_EN.
module pc_step_ctrl
  import picomips_pkg::*;
#(
  parameter int DB_CYCLES = PC_STEP_DB_DEFAULT,
  parameter int TIMEOUT   = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_req,
  input  logic btn_n,
  output logic PCincr,
  output logic waiting,
  output logic timeout
);

  if (DB_CYCLES < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("pc_step_ctrl: DB_CYCLES must be >= 2 and TIMEOUT >= 1");
  end

  step_state_t state;
  step_state_t state_nx;
  logic        db_level;
  logic        tmo_hit;
  logic        pc_c;
  logic        wt_c;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .db_level(db_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

`ifdef PC_STEP_TIMEOUT_EN
  logic [PC_STEP_TMO_W-1:0] tmo_cnt;
  logic                     tmo_flag;

  assign tmo_hit = is_stalled(state) && (tmo_cnt == PC_STEP_TMO_W'(TIMEOUT - 1));

  // counter is zero on every entry to ARMED because it is held clear outside the stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (is_stalled(state)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      tmo_flag <= tmo_hit;
    end
  end

  assign timeout = reset && (state == STEP) && tmo_flag;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    pc_c     = 1'b0;
    wt_c     = is_stalled(state);
    case (state)
      RUN: begin
        pc_c = !wait_req;
        if (wait_req) state_nx = ARMED;
      end
      // a button still held from an earlier WAIT must be released before a press counts
      ARMED: begin
        if (tmo_hit)       state_nx = STEP;
        else if (db_level) state_nx = PRESS;
      end
      PRESS: begin
        if (tmo_hit)        state_nx = STEP;
        else if (!db_level) state_nx = RELEASE;
      end
      RELEASE: begin
        if (tmo_hit || db_level) state_nx = STEP;
      end
      STEP: begin
        pc_c     = 1'b1;
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  assign PCincr  = reset && pc_c;
  assign waiting = reset && wt_c;

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Bench for pc_step_ctrl with DB_CYCLES=4, TIMEOUT=20 (timeout table when PC_STEP_TIMEOUT_EN).
module tb_pc_step_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic wait_req = 1'b0;
  logic btn_n = 1'b1;
  logic PCincr, waiting, timeout;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string name;
    logic  rst;
    logic  w;
    logic  b;
    int    n;
    logic  pc;
    logic  wt;
    logic  tmo;
  } seg_t;

  typedef struct {
    string name;
    int    idx;
    logic  pc;
    logic  wt;
    logic  tmo;
  } exp_t;

  seg_t tbl[$];
  exp_t sb[$];

  pc_step_ctrl #(
    .DB_CYCLES(4),
    .TIMEOUT  (20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wait_req(wait_req),
    .btn_n   (btn_n),
    .PCincr  (PCincr),
    .waiting (waiting),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic void add(string nm, logic r, logic w, logic b, int n,
                              logic pc, logic wt, logic tmo);
    seg_t s;
    s.name = nm; s.rst = r; s.w = w; s.b = b; s.n = n;
    s.pc = pc; s.wt = wt; s.tmo = tmo;
    tbl.push_back(s);
  endfunction

  task automatic check(string nm, int idx, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %b expected %b", nm, idx, $time, act, exp);
    end
  endtask

  task automatic drive(logic r, logic w, logic b);
    @(posedge clk);
    #1;
    reset    = r;
    wait_req = w;
    btn_n    = b;
  endtask

  task automatic compare_head();
    exp_t e;
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".PCincr"},  e.idx, PCincr,  e.pc);
    check({e.name, ".waiting"}, e.idx, waiting, e.wt);
    check({e.name, ".timeout"}, e.idx, timeout, e.tmo);
  endtask

  task automatic run_seg(seg_t s);
    exp_t e;
    for (int i = 0; i < s.n; i++) begin
      drive(s.rst, s.w, s.b);
      e.name = s.name; e.idx = i; e.pc = s.pc; e.wt = s.wt; e.tmo = s.tmo;
      sb.push_back(e);
      compare_head();
    end
  endtask

  initial begin
    //           name        rst w  b  n   pc wt tmo
    add("reset",      0, 1, 1, 3,  0, 0, 0);
    add("rst_rel",    1, 1, 1, 1,  0, 0, 0);
`ifdef PC_STEP_TIMEOUT_EN
    add("tmo_wait",   1, 1, 1, 20, 0, 1, 0);
    add("tmo_step",   1, 0, 1, 1,  1, 0, 1);
    add("tmo_run",    1, 0, 1, 3,  1, 0, 0);
`else
    add("arm",        1, 1, 1, 4,  0, 1, 0);
    add("press",      1, 1, 0, 10, 0, 1, 0);
    add("release",    1, 1, 1, 7,  0, 1, 0);
    add("step",       1, 0, 1, 1,  1, 0, 0);
    add("run",        1, 0, 1, 3,  1, 0, 0);
    add("g_enter",    1, 1, 1, 1,  0, 0, 0);
    add("g_arm",      1, 1, 1, 3,  0, 1, 0);
    add("glitch",     1, 1, 0, 3,  0, 1, 0);
    add("g_hold",     1, 1, 1, 10, 0, 1, 0);
    add("g_press",    1, 1, 0, 8,  0, 1, 0);
    add("g_rel_wdrop",1, 0, 1, 7,  0, 1, 0);
    add("g_step",     1, 0, 1, 1,  1, 0, 0);
    add("g_run",      1, 0, 1, 2,  1, 0, 0);
    add("h_run_held", 1, 0, 0, 8,  1, 0, 0);
    add("h_enter",    1, 1, 0, 1,  0, 0, 0);
    add("h_armed",    1, 1, 0, 5,  0, 1, 0);
    add("h_release",  1, 1, 1, 10, 0, 1, 0);
    add("h_press",    1, 1, 0, 8,  0, 1, 0);
    add("h_rel",      1, 1, 1, 7,  0, 1, 0);
    add("h_step",     1, 0, 1, 1,  1, 0, 0);
    add("h_run",      1, 0, 1, 2,  1, 0, 0);
    add("b1_enter",   1, 1, 1, 1,  0, 0, 0);
    add("b1_arm",     1, 1, 1, 3,  0, 1, 0);
    add("b1_press",   1, 1, 0, 8,  0, 1, 0);
    add("b1_rel",     1, 1, 1, 7,  0, 1, 0);
    add("b1_step",    1, 1, 1, 1,  1, 0, 0);
    add("b2_enter",   1, 1, 1, 1,  0, 0, 0);
    add("b2_arm",     1, 1, 1, 3,  0, 1, 0);
    add("b2_press",   1, 1, 0, 8,  0, 1, 0);
    add("b2_rel",     1, 1, 1, 7,  0, 1, 0);
    add("b2_step",    1, 0, 1, 1,  1, 0, 0);
    add("b2_run",     1, 0, 1, 2,  1, 0, 0);
    add("m_enter",    1, 1, 1, 1,  0, 0, 0);
    add("m_arm",      1, 1, 1, 3,  0, 1, 0);
    add("m_press",    1, 1, 0, 8,  0, 1, 0);
    add("m_reset",    0, 1, 1, 2,  0, 0, 0);
    add("m_rel",      1, 1, 1, 1,  0, 0, 0);
    add("m_rearm",    1, 1, 1, 5,  0, 1, 0);
`endif

    for (int k = 0; k < tbl.size(); k++) run_seg(tbl[k]);

`ifndef PC_STEP_TIMEOUT_EN
    // hand-written: release-edge to step-pulse latency, bounded
    begin
      int lat;
      bit seen;
      for (int i = 0; i < 8; i++) begin
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("lat_press.waiting", i, waiting, 1'b1);
      end
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        if (PCincr === 1'b1) begin
          seen = 1'b1;
          lat  = i;
        end
      end
      check("lat_seen", 0, seen, 1'b1);
      n_vec++;
      if (lat != 7) begin
        n_bad++;
        $display("FAIL lat_cycles: got %0d expected 7", lat);
      end
      drive(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("lat_after.waiting", 0, waiting, 1'b0);
      check("lat_after.PCincr", 0, PCincr, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
